// File: rtl/tlb_op_ctrl.sv
// Privileged TLB instruction sequencer: drives the TLB array's read, write,
// flush and borrowed search-1 ports for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB.
module tlb_op_ctrl #(
  parameter int TLBNUM     = 16,
  parameter int TLBNUMSIZE = 4,
  parameter int PT_W       = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            op_code,
  input  logic                  op_cancel,
  input  logic [4:0]            inv_op,
  input  logic [9:0]            inv_asid,
  input  logic [18:0]           inv_va,
  input  logic [TLBNUMSIZE-1:0] csr_index,
  input  logic [5:0]            csr_ps,
  input  logic                  csr_ne,
  input  logic [18:0]           csr_vppn,
  input  logic [9:0]            csr_asid,
  input  logic                  csr_g,
  input  logic [PT_W-1:0]       csr_pt0,
  input  logic [PT_W-1:0]       csr_pt1,
  output logic                  srch_req,
  input  logic                  srch_gnt,
  output logic [18:0]           srch_vppn,
  output logic [9:0]            srch_asid,
  output logic                  srch_odd,
  input  logic [TLBNUMSIZE-1:0] s1_index,
  input  logic                  s1_ne,
  output logic [TLBNUMSIZE-1:0] r_index,
  input  logic [5:0]            r_ps,
  input  logic [9:0]            r_asid,
  input  logic                  r_ne,
  input  logic                  r_g,
  input  logic [18:0]           r_vppn,
  input  logic [PT_W-1:0]       r_phytran0,
  input  logic [PT_W-1:0]       r_phytran1,
  output logic                  we,
  output logic [TLBNUMSIZE-1:0] w_index,
  output logic [5:0]            w_ps,
  output logic                  w_ne,
  output logic [9:0]            w_asid,
  output logic [18:0]           w_vppn,
  output logic                  w_g,
  output logic [PT_W-1:0]       w_phytran0,
  output logic [PT_W-1:0]       w_phytran1,
  output logic                  fe,
  output logic [9:0]            f_asid,
  output logic [18:0]           f_va,
  output logic [2:0]            f_op,
  output logic                  resp_valid,
  output logic [2:0]            resp_code,
  output logic [TLBNUMSIZE-1:0] res_index,
  output logic                  res_ne,
  output logic [5:0]            res_ps,
  output logic [9:0]            res_asid,
  output logic [18:0]           res_vppn,
  output logic                  res_g,
  output logic [PT_W-1:0]       res_pt0,
  output logic [PT_W-1:0]       res_pt1,
  output logic                  inv_err,
  output logic                  refetch
);

  typedef enum logic [2:0] {
    S_IDLE, S_SRCH, S_RD, S_WR, S_FILL, S_INV, S_DONE
  } state_t;

  state_t state, state_n;

  logic [TLBNUMSIZE-1:0] fill_ctr;

  // Operand registers, loaded on acceptance; pure data, so no reset.
  logic [2:0]            code_p0;
  logic [4:0]            inv_op_p0;
  logic [9:0]            inv_asid_p0;
  logic [18:0]           inv_va_p0;
  logic [TLBNUMSIZE-1:0] index_p0;
  logic [5:0]            ps_p0;
  logic                  ne_p0;
  logic [18:0]           vppn_p0;
  logic [9:0]            asid_p0;
  logic                  g_p0;
  logic [PT_W-1:0]       pt0_p0;
  logic [PT_W-1:0]       pt1_p0;

  logic accept, cap_srch, cap_rd, cap_w, cap_clr, inv_bad;

  assign srch_odd = 1'b0;
  assign accept   = (state == S_IDLE) && op_valid && !op_cancel;
  assign inv_bad  = (inv_op_p0 > 5'd6);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      fill_ctr <= '0;
    end else begin
      state    <= state_n;
      fill_ctr <= (fill_ctr == TLBNUMSIZE'(TLBNUM - 1)) ? '0 : fill_ctr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      code_p0     <= op_code;
      inv_op_p0   <= inv_op;
      inv_asid_p0 <= inv_asid;
      inv_va_p0   <= inv_va;
      index_p0    <= csr_index;
      ps_p0       <= csr_ps;
      ne_p0       <= csr_ne;
      vppn_p0     <= csr_vppn;
      asid_p0     <= csr_asid;
      g_p0        <= csr_g;
      pt0_p0      <= csr_pt0;
      pt1_p0      <= csr_pt1;
    end
  end

  always_comb begin
    state_n    = state;
    op_ready   = 1'b0;
    srch_req   = 1'b0;
    srch_vppn  = '0;
    srch_asid  = '0;
    r_index    = '0;
    we         = 1'b0;
    w_index    = '0;
    w_ps       = '0;
    w_ne       = 1'b0;
    w_asid     = '0;
    w_vppn     = '0;
    w_g        = 1'b0;
    w_phytran0 = '0;
    w_phytran1 = '0;
    fe         = 1'b0;
    f_asid     = '0;
    f_va       = '0;
    f_op       = '0;
    resp_valid = 1'b0;
    resp_code  = '0;
    inv_err    = 1'b0;
    refetch    = 1'b0;
    cap_srch   = 1'b0;
    cap_rd     = 1'b0;
    cap_w      = 1'b0;
    cap_clr    = 1'b0;
    case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (accept) begin
          case (op_code)
            3'd0:    state_n = S_SRCH;
            3'd1:    state_n = S_RD;
            3'd2:    state_n = S_WR;
            3'd3:    state_n = S_FILL;
            3'd4:    state_n = S_INV;
            default: begin
              state_n = S_DONE;
              cap_clr = 1'b1;
            end
          endcase
        end
      end
      S_SRCH: begin
        srch_req  = 1'b1;
        srch_vppn = vppn_p0;
        srch_asid = asid_p0;
        if (op_cancel) begin
          state_n = S_IDLE;
        end else if (srch_gnt) begin
          cap_srch = 1'b1;
          state_n  = S_DONE;
        end
      end
      S_RD: begin
        r_index = index_p0;
        cap_rd  = !op_cancel;
        state_n = op_cancel ? S_IDLE : S_DONE;
      end
      S_WR, S_FILL: begin
        we         = !op_cancel && !reset;
        w_index    = (state == S_WR) ? index_p0 : fill_ctr;
        w_ps       = ps_p0;
        w_ne       = ne_p0;
        w_asid     = asid_p0;
        w_vppn     = vppn_p0;
        w_g        = g_p0;
        w_phytran0 = pt0_p0;
        w_phytran1 = pt1_p0;
        cap_w      = !op_cancel;
        state_n    = op_cancel ? S_IDLE : S_DONE;
      end
      S_INV: begin
        // Out-of-range INVTLB ops never reach the array; they raise INE at DONE.
        fe      = !op_cancel && !reset && !inv_bad;
        f_op    = inv_op_p0[2:0];
        f_asid  = inv_asid_p0;
        f_va    = inv_va_p0;
        state_n = op_cancel ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        resp_code  = code_p0;
        inv_err    = (code_p0 == 3'd4) && inv_bad;
        refetch    = (code_p0 == 3'd2) || (code_p0 == 3'd3) ||
                     ((code_p0 == 3'd4) && !inv_bad);
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || cap_clr) begin
      res_index <= '0;
      res_ne    <= 1'b0;
      res_ps    <= '0;
      res_asid  <= '0;
      res_vppn  <= '0;
      res_g     <= 1'b0;
      res_pt0   <= '0;
      res_pt1   <= '0;
    end else if (cap_srch) begin
      res_ne <= s1_ne;
      if (!s1_ne) res_index <= s1_index;
    end else if (cap_rd) begin
      res_ne   <= r_ne;
      res_ps   <= r_ne ? '0 : r_ps;
      res_asid <= r_ne ? '0 : r_asid;
      res_vppn <= r_ne ? '0 : r_vppn;
      res_g    <= r_ne ? 1'b0 : r_g;
      res_pt0  <= r_ne ? '0 : r_phytran0;
      res_pt1  <= r_ne ? '0 : r_phytran1;
    end else if (cap_w) begin
      res_index <= w_index;
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: directed ops with hand-computed responses,
// a small TLB array model behind the read/search ports, and a decoupled monitor.
module tb_tlb_op_ctrl;
  localparam int N = 16, NS = 4, PTW = 26;
  localparam logic [PTW-1:0] PA = 26'h0ABCDEF, PB = 26'h1FEDCBA;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic op_valid = 1'b0, op_cancel = 1'b0;
  logic op_ready;
  logic [2:0] op_code = '0;
  logic [4:0] inv_op = '0;
  logic [9:0] inv_asid = '0;
  logic [18:0] inv_va = '0;
  logic [NS-1:0] csr_index = '0;
  logic [5:0] csr_ps = '0;
  logic csr_ne = 1'b0, csr_g = 1'b0;
  logic [18:0] csr_vppn = '0;
  logic [9:0] csr_asid = '0;
  logic [PTW-1:0] csr_pt0 = '0, csr_pt1 = '0;
  logic srch_req, srch_gnt = 1'b1, srch_odd;
  logic [18:0] srch_vppn;
  logic [9:0] srch_asid;
  logic [NS-1:0] s1_index, r_index, w_index, res_index;
  logic s1_ne, r_ne, r_g, we, w_ne, w_g, fe;
  logic [5:0] r_ps, w_ps, res_ps;
  logic [9:0] r_asid, w_asid, f_asid, res_asid;
  logic [18:0] r_vppn, w_vppn, f_va, res_vppn;
  logic [PTW-1:0] r_phytran0, r_phytran1, w_phytran0, w_phytran1, res_pt0, res_pt1;
  logic [2:0] f_op, resp_code;
  logic resp_valid, res_ne, res_g, inv_err, refetch;

  always #5 clk = ~clk;

  tlb_op_ctrl #(.TLBNUM(N), .TLBNUMSIZE(NS), .PT_W(PTW)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_cancel(op_cancel), .inv_op(inv_op), .inv_asid(inv_asid),
    .inv_va(inv_va), .csr_index(csr_index), .csr_ps(csr_ps), .csr_ne(csr_ne),
    .csr_vppn(csr_vppn), .csr_asid(csr_asid), .csr_g(csr_g), .csr_pt0(csr_pt0),
    .csr_pt1(csr_pt1), .srch_req(srch_req), .srch_gnt(srch_gnt), .srch_vppn(srch_vppn),
    .srch_asid(srch_asid), .srch_odd(srch_odd), .s1_index(s1_index), .s1_ne(s1_ne),
    .r_index(r_index), .r_ps(r_ps), .r_asid(r_asid), .r_ne(r_ne), .r_g(r_g),
    .r_vppn(r_vppn), .r_phytran0(r_phytran0), .r_phytran1(r_phytran1), .we(we),
    .w_index(w_index), .w_ps(w_ps), .w_ne(w_ne), .w_asid(w_asid), .w_vppn(w_vppn),
    .w_g(w_g), .w_phytran0(w_phytran0), .w_phytran1(w_phytran1), .fe(fe),
    .f_asid(f_asid), .f_va(f_va), .f_op(f_op), .resp_valid(resp_valid),
    .resp_code(resp_code), .res_index(res_index), .res_ne(res_ne), .res_ps(res_ps),
    .res_asid(res_asid), .res_vppn(res_vppn), .res_g(res_g), .res_pt0(res_pt0),
    .res_pt1(res_pt1), .inv_err(inv_err), .refetch(refetch)
  );

  // TLB array model: every entry starts invalid with non-zero junk fields.
  logic e_ne [N];
  logic [18:0] e_vppn [N];
  logic [9:0] e_asid [N];
  logic [5:0] e_ps [N];
  logic e_g [N];
  logic [PTW-1:0] e_pt0 [N], e_pt1 [N];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        e_ne[i] <= 1'b1; e_vppn[i] <= '1; e_asid[i] <= '1; e_ps[i] <= '1;
        e_g[i] <= 1'b1; e_pt0[i] <= '1; e_pt1[i] <= '1;
      end
    end else if (we) begin
      e_ne[w_index] <= w_ne; e_vppn[w_index] <= w_vppn; e_asid[w_index] <= w_asid;
      e_ps[w_index] <= w_ps; e_g[w_index] <= w_g;
      e_pt0[w_index] <= w_phytran0; e_pt1[w_index] <= w_phytran1;
    end
  end

  assign r_ne = e_ne[r_index];
  assign r_vppn = e_vppn[r_index];
  assign r_asid = e_asid[r_index];
  assign r_ps = e_ps[r_index];
  assign r_g = e_g[r_index];
  assign r_phytran0 = e_pt0[r_index];
  assign r_phytran1 = e_pt1[r_index];

  always_comb begin
    s1_ne = 1'b1;
    s1_index = '0;
    for (int i = 0; i < N; i++)
      if (!e_ne[i] && e_vppn[i] == srch_vppn && (e_g[i] || e_asid[i] == srch_asid)) begin
        s1_ne = 1'b0;
        s1_index = NS'(i);
      end
  end

  typedef struct packed {
    logic [2:0] code; logic [NS-1:0] idx; logic ne; logic [5:0] ps; logic [9:0] asid;
    logic [18:0] vppn; logic g; logic [PTW-1:0] pt0; logic [PTW-1:0] pt1;
    logic err; logic rf;
  } resp_t;
  typedef struct packed {
    logic [NS-1:0] idx; logic [5:0] ps; logic ne; logic [9:0] asid; logic [18:0] vppn;
    logic g; logic [PTW-1:0] pt0; logic [PTW-1:0] pt1;
  } wr_t;
  typedef struct packed { logic [2:0] op; logic [9:0] asid; logic [18:0] va; } fl_t;

  resp_t rq[$]; int rdue[$];
  wr_t wq[$];   int wdue[$];
  fl_t fq[$];   int fdue[$];

  int checks = 0, passes = 0, cyc = 0;
  logic [3:0] fctr;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) fctr <= reset ? 4'd0 : fctr + 4'd1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic resp_t mk(input logic [2:0] code, input logic [NS-1:0] idx,
      input logic ne, input logic [5:0] ps, input logic [9:0] asid,
      input logic [18:0] vppn, input logic g, input logic [PTW-1:0] pt0,
      input logic [PTW-1:0] pt1, input logic err, input logic rf);
    mk = {code, idx, ne, ps, asid, vppn, g, pt0, pt1, err, rf};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a response/write/flush.
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid) begin
        if (rq.size() == 0) check("resp_unexpected", 128'(resp_valid), 128'(0));
        else begin
          check("resp", 128'({resp_code, res_index, res_ne, res_ps, res_asid, res_vppn,
                res_g, res_pt0, res_pt1, inv_err, refetch}), 128'(rq.pop_front()));
          check("resp_cycle", 128'(cyc), 128'(rdue.pop_front()));
        end
      end
      if (we) begin
        if (wq.size() == 0) check("we_unexpected", 128'(we), 128'(0));
        else begin
          check("write", 128'({w_index, w_ps, w_ne, w_asid, w_vppn, w_g, w_phytran0,
                w_phytran1}), 128'(wq.pop_front()));
          check("write_cycle", 128'(cyc), 128'(wdue.pop_front()));
        end
      end
      if (fe) begin
        if (fq.size() == 0) check("fe_unexpected", 128'(fe), 128'(0));
        else begin
          check("flush", 128'({f_op, f_asid, f_va}), 128'(fq.pop_front()));
          check("flush_cycle", 128'(cyc), 128'(fdue.pop_front()));
        end
      end
    end
  end

  task automatic idle_wait();
    int n = 0;
    while (!op_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!op_ready) check("ready_timeout", 128'(op_ready), 128'(1));
  endtask

  task automatic issue(input logic [2:0] code, output int k0);
    idle_wait();
    op_code = code; op_valid = 1'b1; k0 = cyc;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic set_csr(input logic [NS-1:0] idx, input logic [5:0] ps, input logic ne,
      input logic [18:0] vppn, input logic [9:0] asid, input logic g,
      input logic [PTW-1:0] pt0, input logic [PTW-1:0] pt1);
    csr_index = idx; csr_ps = ps; csr_ne = ne; csr_vppn = vppn;
    csr_asid = asid; csr_g = g; csr_pt0 = pt0; csr_pt1 = pt1;
  endtask

  initial begin
    int k, k2, n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_ready", 128'(op_ready), 128'(1));
    check("reset_ctl", 128'({resp_valid, we, fe, srch_req, refetch, inv_err, resp_code}), 128'(0));
    check("reset_res", 128'({res_index, res_ne, res_ps, res_asid, res_vppn, res_g,
          res_pt0, res_pt1}), 128'(0));

    // RD of invalid entry 5: only res_ne set.
    set_csr(4'd5, 6'd0, 1'b0, 19'h0, 10'h0, 1'b0, '0, '0);
    issue(3'd1, k);
    rq.push_back(mk(3'd1, 4'd0, 1'b1, 6'd0, 10'd0, 19'd0, 1'b0, '0, '0, 1'b0, 1'b0)); rdue.push_back(k + 2);

    // WR entry 3, then SRCH hits it.
    set_csr(4'd3, 6'd12, 1'b0, 19'h12345, 10'd7, 1'b0, PA, PB);
    issue(3'd2, k);
    wq.push_back({4'd3, 6'd12, 1'b0, 10'd7, 19'h12345, 1'b0, PA, PB}); wdue.push_back(k + 1);
    rq.push_back(mk(3'd2, 4'd3, 1'b1, 6'd0, 10'd0, 19'd0, 1'b0, '0, '0, 1'b0, 1'b1)); rdue.push_back(k + 2);

    set_csr(4'd0, 6'd0, 1'b1, 19'h12345, 10'd7, 1'b0, '0, '0);
    issue(3'd0, k);
    rq.push_back(mk(3'd0, 4'd3, 1'b0, 6'd0, 10'd0, 19'd0, 1'b0, '0, '0, 1'b0, 1'b0)); rdue.push_back(k + 2);

    set_csr(4'd3, 6'd0, 1'b1, 19'h0, 10'd0, 1'b0, '0, '0);
    issue(3'd1, k);
    rq.push_back(mk(3'd1, 4'd3, 1'b0, 6'd12, 10'd7, 19'h12345, 1'b0, PA, PB, 1'b0, 1'b0)); rdue.push_back(k + 2);

    // SRCH miss with the grant withheld for four cycles.
    srch_gnt = 1'b0;
    set_csr(4'd0, 6'd0, 1'b0, 19'h11111, 10'd7, 1'b0, '0, '0);
    issue(3'd0, k);
    rq.push_back(mk(3'd0, 4'd3, 1'b1, 6'd12, 10'd7, 19'h12345, 1'b0, PA, PB, 1'b0, 1'b0)); rdue.push_back(k + 6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("srch_stall", 128'({srch_req, srch_vppn, srch_asid, srch_odd}), 128'({1'b1, 19'h11111, 10'd7, 1'b0}));
      @(posedge clk); #1;
    end
    srch_gnt = 1'b1;

    // Two FILLs three cycles apart; fill_ctr 15 then wraps to 2.
    set_csr(4'd9, 6'd13, 1'b0, 19'h00abc, 10'd2, 1'b1, PB, PA);
    idle_wait();
    n = 0;
    while (fctr != 4'd14 && n < 20) begin @(posedge clk); #1; n++; end
    issue(3'd3, k);
    wq.push_back({4'd15, 6'd13, 1'b0, 10'd2, 19'h00abc, 1'b1, PB, PA}); wdue.push_back(k + 1);
    rq.push_back(mk(3'd3, 4'd15, 1'b1, 6'd12, 10'd7, 19'h12345, 1'b0, PA, PB, 1'b0, 1'b1)); rdue.push_back(k + 2);
    csr_vppn = 19'h00def;
    issue(3'd3, k2);
    wq.push_back({4'd2, 6'd13, 1'b0, 10'd2, 19'h00def, 1'b1, PB, PA}); wdue.push_back(k + 4);
    rq.push_back(mk(3'd3, 4'd2, 1'b1, 6'd12, 10'd7, 19'h12345, 1'b0, PA, PB, 1'b0, 1'b1)); rdue.push_back(k + 5);

    // INVTLB op 5 flushes; op 9 raises INE with no flush.
    inv_op = 5'd5; inv_asid = 10'd7; inv_va = 19'h12345;
    issue(3'd4, k);
    fq.push_back({3'd5, 10'd7, 19'h12345}); fdue.push_back(k + 1);
    rq.push_back(mk(3'd4, 4'd2, 1'b1, 6'd12, 10'd7, 19'h12345, 1'b0, PA, PB, 1'b0, 1'b1)); rdue.push_back(k + 2);
    inv_op = 5'd9;
    issue(3'd4, k);
    rq.push_back(mk(3'd4, 4'd2, 1'b1, 6'd12, 10'd7, 19'h12345, 1'b0, PA, PB, 1'b1, 1'b0)); rdue.push_back(k + 2);

    // Reserved op code clears results.
    issue(3'd6, k);
    rq.push_back(mk(3'd6, 4'd0, 1'b0, 6'd0, 10'd0, 19'd0, 1'b0, '0, '0, 1'b0, 1'b0)); rdue.push_back(k + 1);

    // WR cancelled in its own cycle.
    set_csr(4'd7, 6'd1, 1'b0, 19'h55555, 10'd1, 1'b0, PA, PA);
    issue(3'd2, k);
    op_cancel = 1'b1;
    @(negedge clk);
    check("cancel_we", 128'(we), 128'(0));
    @(posedge clk); #1;
    op_cancel = 1'b0;
    check("cancel_ready", 128'(op_ready), 128'(1));

    // Cancel coincident with op_valid in IDLE: not accepted.
    op_code = 3'd1; op_valid = 1'b1; op_cancel = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; op_cancel = 1'b0;
    check("cancel_idle_ready", 128'(op_ready), 128'(1));
    repeat (3) @(posedge clk); #1;

    // Reset in the middle of a WR.
    issue(3'd2, k);
    reset = 1'b1;
    @(negedge clk);
    check("reset_we", 128'(we), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_mid_ready", 128'({op_ready, resp_valid}), 128'({1'b1, 1'b0}));
    check("reset_mid_res", 128'({res_index, res_ne, res_ps, res_asid, res_vppn, res_g,
          res_pt0, res_pt1}), 128'(0));
    repeat (4) @(posedge clk); #1;

    check("resp_drained", 128'(rq.size()), 128'(0));
    check("write_drained", 128'(wq.size()), 128'(0));
    check("flush_drained", 128'(fq.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", checks, passes);
    $fatal(1, "watchdog");
  end
endmodule
